arp_table_learner: RTL and testbench
====================================

Name: arp_table_learner

Overview:
- Writer-side counterpart of the output-port-lookup ARP table: snoops the 256-bit packet stream for ARP replies (optionally requests), extracts sender IP/MAC, and writes entries into the 32-entry ARP table write port.
- Also arbitrates host-register (software) table writes onto the same port.
- Sits between the RX queues and output_port_lookup; the stream passes through unmodified.

Parameters:
C_AXIS_DATA_WIDTH, 256, stream data width (field offsets below assume 256)
C_AXIS_TUSER_WIDTH, 128, stream TUSER width
SRC_PORT_POS, 16, LSB of the 8-bit one-hot source-port field in TUSER
LEARN_BASE, 16, first table index usable for learned entries; indices below it are software-only
LEARN_REQUESTS, 0, when 1 also learn from ARP requests (oper=1)

Ports:
AXI_ACLK  in  1  clock
reset  in  1  synchronous, active-high reset
S_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST  in  256/32/128/1/1  upstream stream
S_AXIS_TREADY  out  1  = M_AXIS_TREADY
M_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST  out  256/32/128/1/1  combinational copy of S_AXIS_*
M_AXIS_TREADY  in  1  downstream ready
sw_wr_req  in  1  one-cycle software write pulse
sw_wr_addr  in  5  software table index
sw_wr_data  in  96  {16'h0, MAC[47:0], IP[31:0]}
sw_wr_ack  out  1  one-cycle pulse when the software write completes
tbl_wr_req  out  1  one-cycle write strobe to the ARP table
tbl_wr_addr  out  5  table index
tbl_wr_data  out  96  entry; [31:0] IP, [79:32] MAC, [95:80] zero
tbl_wr_ack  in  1  table write ack (arrives the cycle after tbl_wr_req)
learn_en  in  1  learning enable
counter_clr  in  1  synchronous clear of both counters
learn_count  out  32  learned writes completed
learn_drop_count  out  32  qualifying ARP packets dropped (learner busy)

Behaviour:
- Reset: state IDLE; tbl_wr_req=0; sw_wr_ack=0; pending software write cleared; shadow valid[31:0]=0; replacement pointer=LEARN_BASE; counters=0; SOP tracker=1. Stream path is combinational and never stalled by this block.
- SOP tracking: a beat is SOP when the tracker is 1. Tracker is cleared on a handshaked non-TLAST beat and set on a handshaked TLAST beat.
- Qualify on the handshaked SOP beat (byte 0 = TDATA[255:248]). All of the following must hold:
  - ethertype [159:144]=0x0806, htype [143:128]=1, ptype [127:112]=0x0800, hlen [111:104]=6, plen [103:96]=4
  - oper [95:80]=2, or oper=1 when LEARN_REQUESTS=1
  - TUSER[SRC_PORT_POS+7:SRC_PORT_POS] has an even bit set (physical port)
  - learn_en=1 and SPA [31:0] != 0
- Qualified in IDLE: capture SPA and SHA [79:32]; go to SCAN with idx=0.
- Qualified while not IDLE: learn_drop_count+1, packet ignored.
- Shadow copy: 32x32-bit IP array plus valid bits, updated on every completed table write (software or learned).
- SCAN: one entry per cycle.
  - valid[idx] && shadow[idx]==SPA at idx >= LEARN_BASE: target=idx, go WRITE.
  - Same match at idx < LEARN_BASE (static entry): go IDLE, no write, no count.
  - No match after idx=31: target=replacement pointer, go WRITE.
  - Worst-case learn latency: 33 cycles from capture to tbl_wr_req.
- WRITE: assert tbl_wr_req for one cycle with {16'h0, SHA, SPA}, go WAIT_ACK. If a software write is pending, it takes this cycle and the learner retries next cycle.
- WAIT_ACK: on tbl_wr_ack, learn_count+1; if the entry was a miss-allocation, advance the pointer (31 wraps to LEARN_BASE); go IDLE.
- Software path: sw_wr_req latches into a 1-deep pending register.
  - Issued when the port is free (not WAIT_ACK for the learner); software has priority over learned writes in the same cycle.
  - sw_wr_ack pulses the cycle tbl_wr_ack returns for it.
  - A new sw_wr_req while one is pending overwrites it (the host serializes on ack).
- Hazard: if a software write completes during SCAN or WRITE with data[31:0]==captured SPA, the learn aborts to IDLE with no write and no count.
- Counters: counter_clr=1 zeroes both counters, overriding same-cycle increments; they saturate at 0xFFFFFFFF.
- reset asserted mid-learn: write abandoned, no tbl_wr_req issued afterwards.

Test Plan:
- ARP reply SPA=10.0.0.5, SHA=00:11:22:33:44:55, from port0 (TUSER[16]=1), empty table -> tbl_wr_req at addr 16 with data 0x0000_001122334455_0A000005; learn_count=1; output stream bit-identical.
- Same reply repeated with SHA=AA:BB:CC:DD:EE:FF -> rewrite at addr 16, pointer unchanged at 17; learn_count=2.
- Software write addr 3, IP 10.0.0.9, followed by a reply from 10.0.0.9 -> sw_wr_ack pulses once; the learner performs no write; learn_count unchanged.
- Two back-to-back 1-beat ARP replies -> first learned; learn_drop_count=1.
- 17 distinct replies learned -> addresses 16..31, then 16 again (wrap).
- ARP request with LEARN_REQUESTS=0, or a reply from the CPU port (TUSER[17]=1), or learn_en=0 -> no tbl_wr_req; counters unchanged.

Source files
------------

// File: rtl/arp_table_learner.sv
// ARP table learner: snoops the RX stream for ARP replies (optionally requests),
// learns sender IP/MAC into the ARP table write port, and shares that port with
// host-register writes. The stream itself passes through combinationally.
//
// state    | meaning
// IDLE     | waiting for a qualifying ARP SOP beat
// SCAN     | comparing captured SPA against one shadow entry per cycle
// WRITE    | issuing the learned entry (yields to a pending software write)
// WAIT_ACK | learned write outstanding, waiting for tbl_wr_ack
module arp_table_learner #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS       = 16,
  parameter int LEARN_BASE         = 16,
  parameter bit LEARN_REQUESTS     = 1'b0
) (
  input  logic                             AXI_ACLK,
  input  logic                             reset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]    S_AXIS_TUSER,
  input  logic                             S_AXIS_TVALID,
  input  logic                             S_AXIS_TLAST,
  output logic                             S_AXIS_TREADY,
  output logic [C_AXIS_DATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic [C_AXIS_TUSER_WIDTH-1:0]    M_AXIS_TUSER,
  output logic                             M_AXIS_TVALID,
  output logic                             M_AXIS_TLAST,
  input  logic                             M_AXIS_TREADY,
  input  logic                             sw_wr_req,
  input  logic [4:0]                       sw_wr_addr,
  input  logic [95:0]                      sw_wr_data,
  output logic                             sw_wr_ack,
  output logic                             tbl_wr_req,
  output logic [4:0]                       tbl_wr_addr,
  output logic [95:0]                      tbl_wr_data,
  input  logic                             tbl_wr_ack,
  input  logic                             learn_en,
  input  logic                             counter_clr,
  output logic [31:0]                      learn_count,
  output logic [31:0]                      learn_drop_count
);

  typedef enum logic [1:0] {IDLE, SCAN, WRITE, WAIT_ACK} state_t;

  localparam logic [4:0] LB = 5'(LEARN_BASE);

  state_t      state, state_n;
  logic [4:0]  idx, idx_n, target, target_n, ptr;
  logic        miss_alloc, miss_alloc_n;
  logic [31:0] spa_q;
  logic [47:0] sha_q;
  logic [31:0] shadow [32];
  logic [31:0] valid;
  logic        sop;
  logic        sw_pend;
  logic [4:0]  sw_addr_q;
  logic [95:0] sw_data_q;
  logic        ack_pend, ack_sw;
  logic [4:0]  ack_addr;
  logic [31:0] ack_ip;
  logic        hs, is_arp, oper_ok, port_ok, qualify;
  logic        issue_sw, issue_learn, learn_done, sw_done, wr_done, hazard, drop;
  logic [7:0]  src_port;

  assign M_AXIS_TDATA  = S_AXIS_TDATA;
  assign M_AXIS_TSTRB  = S_AXIS_TSTRB;
  assign M_AXIS_TUSER  = S_AXIS_TUSER;
  assign M_AXIS_TVALID = S_AXIS_TVALID;
  assign M_AXIS_TLAST  = S_AXIS_TLAST;
  assign S_AXIS_TREADY = M_AXIS_TREADY;

  assign hs       = S_AXIS_TVALID && M_AXIS_TREADY;
  assign src_port = S_AXIS_TUSER[SRC_PORT_POS +: 8];
  assign port_ok  = (src_port & 8'h55) != 8'h00;
  assign is_arp   = (S_AXIS_TDATA[159:144] == 16'h0806) && (S_AXIS_TDATA[143:128] == 16'h0001) &&
                    (S_AXIS_TDATA[127:112] == 16'h0800) && (S_AXIS_TDATA[111:104] == 8'd6) &&
                    (S_AXIS_TDATA[103:96] == 8'd4);
  assign oper_ok  = (S_AXIS_TDATA[95:80] == 16'd2) || (LEARN_REQUESTS && S_AXIS_TDATA[95:80] == 16'd1);
  assign qualify  = hs && sop && is_arp && oper_ok && port_ok && learn_en && (S_AXIS_TDATA[31:0] != 32'h0);
  assign drop     = qualify && (state != IDLE);

  // Completions: acks always belong to the request issued the previous cycle.
  assign wr_done   = tbl_wr_ack && ack_pend;
  assign sw_done   = wr_done && ack_sw;
  assign sw_wr_ack = sw_done;
  assign hazard    = sw_done && (ack_ip == spa_q);

  // Learner next-state, issue arbitration and table port drive.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    target_n     = target;
    miss_alloc_n = miss_alloc;
    issue_learn  = 1'b0;
    learn_done   = 1'b0;
    issue_sw     = sw_pend && (state != WAIT_ACK);
    case (state)
      IDLE: begin
        if (qualify) begin
          state_n = SCAN;
          idx_n   = 5'd0;
        end
      end
      SCAN: begin
        if (hazard) begin
          state_n = IDLE;
        end else if (valid[idx] && shadow[idx] == spa_q) begin
          if (idx >= LB) begin
            target_n     = idx;
            miss_alloc_n = 1'b0;
            state_n      = WRITE;
          end else begin
            state_n = IDLE;
          end
        end else if (idx == 5'd31) begin
          target_n     = ptr;
          miss_alloc_n = 1'b1;
          state_n      = WRITE;
        end else begin
          idx_n = idx + 5'd1;
        end
      end
      WRITE: begin
        if (hazard) begin
          state_n = IDLE;
        end else if (!sw_pend) begin
          issue_learn = 1'b1;
          state_n     = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (wr_done && !ack_sw) begin
          learn_done = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    tbl_wr_req  = issue_sw || issue_learn;
    tbl_wr_addr = issue_sw ? sw_addr_q : target;
    tbl_wr_data = issue_sw ? sw_data_q : {16'h0, sha_q, spa_q};
  end

  // Learner state, scan index, capture and replacement pointer.
  always_ff @(posedge AXI_ACLK) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 5'd0;
      target     <= LB;
      miss_alloc <= 1'b0;
      ptr        <= LB;
      spa_q      <= 32'h0;
      sha_q      <= 48'h0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      target     <= target_n;
      miss_alloc <= miss_alloc_n;
      if (state == IDLE && qualify) begin
        spa_q <= S_AXIS_TDATA[31:0];
        sha_q <= S_AXIS_TDATA[79:32];
      end
      if (learn_done && miss_alloc)
        ptr <= (ptr == 5'd31) ? LB : ptr + 5'd1;
    end
  end

  // SOP tracker follows handshaked beats.
  always_ff @(posedge AXI_ACLK) begin
    if (reset)   sop <= 1'b1;
    else if (hs) sop <= S_AXIS_TLAST;
  end

  // One-deep software write holding register; a newer request overwrites it.
  always_ff @(posedge AXI_ACLK) begin
    if (reset) begin
      sw_pend   <= 1'b0;
      sw_addr_q <= 5'd0;
      sw_data_q <= 96'h0;
    end else if (sw_wr_req) begin
      sw_pend   <= 1'b1;
      sw_addr_q <= sw_wr_addr;
      sw_data_q <= sw_wr_data;
    end else if (issue_sw) begin
      sw_pend <= 1'b0;
    end
  end

  // Remember the in-flight write so its ack can update the shadow copy.
  always_ff @(posedge AXI_ACLK) begin
    if (reset) begin
      ack_pend <= 1'b0;
      ack_sw   <= 1'b0;
      ack_addr <= 5'd0;
      ack_ip   <= 32'h0;
      valid    <= 32'h0;
    end else begin
      ack_pend <= tbl_wr_req;
      ack_sw   <= issue_sw;
      ack_addr <= tbl_wr_addr;
      ack_ip   <= tbl_wr_data[31:0];
      if (wr_done) valid[ack_addr] <= 1'b1;
    end
  end

  // Shadow IP array; contents are qualified by valid so it needs no reset.
  always_ff @(posedge AXI_ACLK) begin
    if (wr_done) shadow[ack_addr] <= ack_ip;
  end

  // Saturating counters; clear wins over a same-cycle increment.
  always_ff @(posedge AXI_ACLK) begin
    if (reset || counter_clr) begin
      learn_count      <= 32'h0;
      learn_drop_count <= 32'h0;
    end else begin
      if (learn_done && learn_count != 32'hFFFF_FFFF) learn_count <= learn_count + 32'd1;
      if (drop && learn_drop_count != 32'hFFFF_FFFF)  learn_drop_count <= learn_drop_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_arp_table_learner.sv
// Bench for arp_table_learner: a table-side responder acks every write one cycle
// later and logs it; a behavioural table model predicts the writes and counters.
module tb_arp_table_learner;
  localparam int LB = 16;

  logic         AXI_ACLK = 1'b0;
  logic         reset;
  logic [255:0] S_AXIS_TDATA;
  logic [31:0]  S_AXIS_TSTRB;
  logic [127:0] S_AXIS_TUSER;
  logic         S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TREADY;
  logic [255:0] M_AXIS_TDATA;
  logic [31:0]  M_AXIS_TSTRB;
  logic [127:0] M_AXIS_TUSER;
  logic         M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY;
  logic         sw_wr_req, sw_wr_ack, tbl_wr_req, tbl_wr_ack, learn_en, counter_clr;
  logic [4:0]   sw_wr_addr, tbl_wr_addr;
  logic [95:0]  sw_wr_data, tbl_wr_data;
  logic [31:0]  learn_count, learn_drop_count;

  int checks = 0;
  int errors = 0;
  int sw_ack_cnt = 0;

  logic [100:0] wr_log[$];
  logic [100:0] exp_q[$];
  logic [31:0]  m_ip[32];
  bit           m_valid[32];
  int           m_ptr;
  int unsigned  m_learn, m_drop;

  always #5 AXI_ACLK = ~AXI_ACLK;

  arp_table_learner dut (
    .AXI_ACLK(AXI_ACLK), .reset(reset),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB), .S_AXIS_TUSER(S_AXIS_TUSER),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB), .M_AXIS_TUSER(M_AXIS_TUSER),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
    .sw_wr_req(sw_wr_req), .sw_wr_addr(sw_wr_addr), .sw_wr_data(sw_wr_data), .sw_wr_ack(sw_wr_ack),
    .tbl_wr_req(tbl_wr_req), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
    .tbl_wr_ack(tbl_wr_ack), .learn_en(learn_en), .counter_clr(counter_clr),
    .learn_count(learn_count), .learn_drop_count(learn_drop_count)
  );

  // Table side: log each write, ack it during the following cycle.
  initial begin
    logic r;
    tbl_wr_ack = 1'b0;
    forever begin
      @(negedge AXI_ACLK);
      r = tbl_wr_req;
      if (r) wr_log.push_back({tbl_wr_addr, tbl_wr_data});
      if (sw_wr_ack) sw_ack_cnt++;
      @(posedge AXI_ACLK);
      #1 tbl_wr_ack = r;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural table model ----------------
  function automatic void m_reset();
    for (int i = 0; i < 32; i++) begin m_valid[i] = 0; m_ip[i] = 32'h0; end
    m_ptr = LB; m_learn = 0; m_drop = 0;
    exp_q.delete();
  endfunction

  function automatic void m_sw(input int addr, input logic [31:0] ip, input logic [47:0] mac);
    m_ip[addr] = ip; m_valid[addr] = 1;
    exp_q.push_back({5'(addr), 16'h0, mac, ip});
  endfunction

  // Lowest-index match wins; static hits are ignored, misses take the pointer.
  function automatic void m_learn_pkt(input logic [31:0] ip, input logic [47:0] mac);
    int hit = -1;
    int addr;
    for (int i = 0; i < 32; i++)
      if (hit < 0 && m_valid[i] && m_ip[i] == ip) hit = i;
    if (hit >= 0 && hit < LB) return;
    if (hit >= 0) addr = hit;
    else begin
      addr = m_ptr;
      m_ptr = (m_ptr == 31) ? LB : m_ptr + 1;
    end
    m_ip[addr] = ip; m_valid[addr] = 1; m_learn++;
    exp_q.push_back({5'(addr), 16'h0, mac, ip});
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [255:0] mk_arp(input logic [15:0] oper, input logic [31:0] ip,
                                          input logic [47:0] mac);
    logic [255:0] d;
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    d[159:144] = 16'h0806; d[143:128] = 16'h0001; d[127:112] = 16'h0800;
    d[111:104] = 8'd6; d[103:96] = 8'd4; d[95:80] = oper; d[79:32] = mac; d[31:0] = ip;
    return d;
  endfunction

  function automatic logic [127:0] mk_user(input int port);
    logic [127:0] u;
    u = {$urandom, $urandom, $urandom, $urandom};
    u[23:16] = 8'h01 << port;
    return u;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge AXI_ACLK);
    #1;
  endtask

  // Drives one beat (entered just after a rising edge) and checks the pass-through.
  task automatic send_beat(input logic [255:0] d, input logic [127:0] u, input logic last);
    logic [31:0] strb;
    strb = $urandom;
    S_AXIS_TDATA = d; S_AXIS_TUSER = u; S_AXIS_TLAST = last; S_AXIS_TSTRB = strb;
    S_AXIS_TVALID = 1'b1;
    @(negedge AXI_ACLK);
    checks++;
    if ({M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TVALID, M_AXIS_TLAST, S_AXIS_TREADY} !==
        {d, strb, u, 1'b1, last, 1'b1}) begin
      errors++;
      $display("FAIL passthrough got %h/%h/%h exp %h/%h/%h", M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TSTRB,
               d, u, strb);
    end
    @(posedge AXI_ACLK); #1;
    S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0;
  endtask

  task automatic sw_write(input int addr, input logic [31:0] ip, input logic [47:0] mac);
    sw_wr_req = 1'b1; sw_wr_addr = 5'(addr); sw_wr_data = {16'h0, mac, ip};
    tick(1);
    sw_wr_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    m_reset();
    wr_log.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    @(negedge AXI_ACLK);
    checks++;
    if ({tbl_wr_req, sw_wr_ack, learn_count, learn_drop_count} !== 66'h0) begin
      errors++;
      $display("FAIL reset_state got req=%b ack=%b lc=%0d dc=%0d exp all 0", tbl_wr_req, sw_wr_ack,
               learn_count, learn_drop_count);
    end
    @(posedge AXI_ACLK); #1;
    reset = 1'b0;
    m_reset();
    wr_log.delete();
  endtask

  task automatic test_learn_basic();
    send_beat(mk_arp(16'd2, 32'h0A000005, 48'h001122334455), mk_user(0), 1'b1);
    m_learn_pkt(32'h0A000005, 48'h001122334455);
    tick(40);
    checks++;
    if (wr_log.size() != 1 || wr_log[0] !== {5'd16, 96'h0000_001122334455_0A000005}) begin
      errors++;
      $display("FAIL learn_basic writes=%0d first=%h exp 1 write %h", wr_log.size(),
               (wr_log.size() > 0) ? wr_log[0] : 101'h0, {5'd16, 96'h0000_001122334455_0A000005});
    end
    checks++;
    if (learn_count !== m_learn) begin
      errors++;
      $display("FAIL learn_basic_count got %0d exp %0d", learn_count, m_learn);
    end
    wr_log.delete(); exp_q.delete();
  endtask

  task automatic test_rewrite();
    send_beat(mk_arp(16'd2, 32'h0A000005, 48'hAABBCCDDEEFF), mk_user(0), 1'b1);
    m_learn_pkt(32'h0A000005, 48'hAABBCCDDEEFF);
    tick(40);
    send_beat(mk_arp(16'd2, 32'h0A000006, 48'h0A0B0C0D0E0F), mk_user(2), 1'b1);
    m_learn_pkt(32'h0A000006, 48'h0A0B0C0D0E0F);
    tick(40);
    checks++;
    if (wr_log.size() != 2 || wr_log[0][100:96] !== 5'd16 || wr_log[1][100:96] !== 5'd17 ||
        wr_log[0] !== exp_q[0] || wr_log[1] !== exp_q[1]) begin
      errors++;
      $display("FAIL rewrite writes=%0d exp 2 (addr 16 rewrite, then 17)", wr_log.size());
    end
    checks++;
    if (learn_count !== m_learn) begin
      errors++;
      $display("FAIL rewrite_count got %0d exp %0d", learn_count, m_learn);
    end
    wr_log.delete(); exp_q.delete();
  endtask

  task automatic test_sw_static();
    int acks0;
    int unsigned lc0;
    acks0 = sw_ack_cnt; lc0 = m_learn;
    sw_write(3, 32'h0A000009, 48'h123456789ABC);
    m_sw(3, 32'h0A000009, 48'h123456789ABC);
    tick(4);
    checks++;
    if (sw_ack_cnt - acks0 != 1) begin
      errors++;
      $display("FAIL sw_ack pulses got %0d exp 1", sw_ack_cnt - acks0);
    end
    send_beat(mk_arp(16'd2, 32'h0A000009, 48'h665544332211), mk_user(4), 1'b1);
    m_learn_pkt(32'h0A000009, 48'h665544332211);
    tick(40);
    checks++;
    if (wr_log.size() != 1 || wr_log[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL sw_static writes=%0d exp only the software write %h", wr_log.size(), exp_q[0]);
    end
    checks++;
    if (learn_count !== lc0 || learn_count !== m_learn) begin
      errors++;
      $display("FAIL sw_static_count got %0d exp %0d", learn_count, lc0);
    end
    wr_log.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    send_beat(mk_arp(16'd2, 32'h0A000011, 48'h111111111111), mk_user(0), 1'b1);
    send_beat(mk_arp(16'd2, 32'h0A000012, 48'h222222222222), mk_user(0), 1'b1);
    m_learn_pkt(32'h0A000011, 48'h111111111111);
    m_drop++;
    tick(40);
    checks++;
    if (wr_log.size() != 1 || wr_log[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL back_to_back writes=%0d exp 1 write %h", wr_log.size(), exp_q[0]);
    end
    checks++;
    if (learn_drop_count !== m_drop || learn_count !== m_learn) begin
      errors++;
      $display("FAIL back_to_back_counts got drop=%0d learn=%0d exp drop=%0d learn=%0d",
               learn_drop_count, learn_count, m_drop, m_learn);
    end
    wr_log.delete(); exp_q.delete();
  endtask

  task automatic test_sop();
    logic [255:0] d;
    d = mk_arp(16'd2, 32'h0A000031, 48'h313131313131);
    d[159:144] = 16'h0800;
    send_beat(d, mk_user(0), 1'b0);
    send_beat(mk_arp(16'd2, 32'h0A000032, 48'h323232323232), mk_user(0), 1'b1);
    tick(40);
    checks++;
    if (wr_log.size() != 0) begin
      errors++;
      $display("FAIL non_sop_beat writes=%0d exp 0", wr_log.size());
    end
    send_beat(mk_arp(16'd2, 32'h0A000033, 48'h333333333333), mk_user(6), 1'b1);
    m_learn_pkt(32'h0A000033, 48'h333333333333);
    tick(40);
    checks++;
    if (wr_log.size() != 1 || wr_log[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL sop_restored writes=%0d exp 1 write %h", wr_log.size(), exp_q[0]);
    end
    wr_log.delete(); exp_q.delete();
  endtask

  task automatic test_negative();
    logic [255:0] d;
    d = mk_arp(16'd2, 32'h0A000041, 48'h414141414141);
    send_beat(mk_arp(16'd1, 32'h0A000041, 48'h414141414141), mk_user(0), 1'b1);
    tick(40);
    send_beat(d, mk_user(1), 1'b1);
    tick(40);
    learn_en = 1'b0;
    send_beat(d, mk_user(0), 1'b1);
    tick(40);
    learn_en = 1'b1;
    send_beat(mk_arp(16'd2, 32'h0, 48'h414141414141), mk_user(0), 1'b1);
    tick(40);
    d[127:112] = 16'h86DD;
    send_beat(d, mk_user(0), 1'b1);
    tick(40);
    checks++;
    if (wr_log.size() != 0) begin
      errors++;
      $display("FAIL negative writes=%0d exp 0", wr_log.size());
    end
    checks++;
    if (learn_count !== m_learn || learn_drop_count !== m_drop) begin
      errors++;
      $display("FAIL negative_counts got learn=%0d drop=%0d exp learn=%0d drop=%0d",
               learn_count, learn_drop_count, m_learn, m_drop);
    end
    wr_log.delete(); exp_q.delete();
  endtask

  task automatic test_hazard();
    send_beat(mk_arp(16'd2, 32'h0A000021, 48'h212121212121), mk_user(0), 1'b1);
    tick(2);
    sw_write(2, 32'h0A000021, 48'hABABABABABAB);
    m_sw(2, 32'h0A000021, 48'hABABABABABAB);
    tick(40);
    checks++;
    if (wr_log.size() != 1 || wr_log[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL hazard writes=%0d exp only software write %h", wr_log.size(), exp_q[0]);
    end
    checks++;
    if (learn_count !== m_learn) begin
      errors++;
      $display("FAIL hazard_count got %0d exp %0d", learn_count, m_learn);
    end
    wr_log.delete(); exp_q.delete();
  endtask

  task automatic test_counter_clr();
    counter_clr = 1'b1;
    tick(1);
    counter_clr = 1'b0;
    m_learn = 0; m_drop = 0;
    @(negedge AXI_ACLK);
    checks++;
    if (learn_count !== 32'd0 || learn_drop_count !== 32'd0) begin
      errors++;
      $display("FAIL counter_clr got learn=%0d drop=%0d exp 0/0", learn_count, learn_drop_count);
    end
    @(posedge AXI_ACLK); #1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_beat(mk_arp(16'd2, 32'h0A000051, 48'h515151515151), mk_user(0), 1'b1);
    tick(5);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(40);
    checks++;
    if (wr_log.size() != 0 || learn_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid writes=%0d learn=%0d exp 0/0", wr_log.size(), learn_count);
    end
    wr_log.delete(); exp_q.delete();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send_beat(mk_arp(16'd2, 32'hC0A80100 + i, 48'h020000000000 + i), mk_user(2 * (i % 4)), 1'b1);
      m_learn_pkt(32'hC0A80100 + i, 48'h020000000000 + i);
      tick(40);
    end
    checks++;
    if (wr_log.size() != 17) begin
      errors++;
      $display("FAIL wrap_count writes=%0d exp 17", wr_log.size());
    end else begin
      for (int i = 0; i < 17; i++) begin
        checks++;
        if (wr_log[i] !== exp_q[i] || wr_log[i][100:96] !== 5'(LB + (i % 16))) begin
          errors++;
          $display("FAIL wrap_entry%0d got %h exp %h", i, wr_log[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (learn_count !== 32'd17) begin
      errors++;
      $display("FAIL wrap_learn_count got %0d exp 17", learn_count);
    end
    wr_log.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int kind;
      logic [31:0] ip;
      logic [47:0] mac;
      ip  = ($urandom_range(0, 9) == 0) ? 32'h0 : 32'h0A000000 + $urandom_range(1, 6);
      mac = {$urandom, 16'($urandom)};
      kind = $urandom_range(0, 4);
      if (kind == 4) begin
        int a;
        a = $urandom_range(0, 31);
        if (ip == 32'h0) ip = 32'h0A000001;
        sw_write(a, ip, mac);
        m_sw(a, ip, mac);
        tick(6);
      end else begin
        int port;
        logic [15:0] oper;
        port = $urandom_range(0, 7);
        oper = ($urandom_range(0, 3) == 0) ? 16'd1 : 16'd2;
        learn_en = ($urandom_range(0, 5) != 0);
        send_beat(mk_arp(oper, ip, mac), mk_user(port), 1'b1);
        if (oper == 16'd2 && port % 2 == 0 && learn_en && ip != 32'h0) m_learn_pkt(ip, mac);
        tick(40);
        learn_en = 1'b1;
      end
      checks++;
      if (wr_log.size() != exp_q.size()) begin
        errors++;
        $display("FAIL random_it%0d writes=%0d exp %0d", it, wr_log.size(), exp_q.size());
      end else begin
        for (int k = 0; k < exp_q.size(); k++) begin
          checks++;
          if (wr_log[k] !== exp_q[k]) begin
            errors++;
            $display("FAIL random_it%0d_write got %h exp %h", it, wr_log[k], exp_q[k]);
          end
        end
      end
      checks++;
      if (learn_count !== m_learn || learn_drop_count !== m_drop) begin
        errors++;
        $display("FAIL random_it%0d_counts got learn=%0d drop=%0d exp learn=%0d drop=%0d", it,
                 learn_count, learn_drop_count, m_learn, m_drop);
      end
      wr_log.delete(); exp_q.delete();
    end
  endtask

  initial begin
    reset = 1'b1;
    S_AXIS_TDATA = '0; S_AXIS_TSTRB = '0; S_AXIS_TUSER = '0;
    S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0; M_AXIS_TREADY = 1'b1;
    sw_wr_req = 1'b0; sw_wr_addr = '0; sw_wr_data = '0;
    learn_en = 1'b1; counter_clr = 1'b0;
    m_reset();
    test_reset();
    test_learn_basic();
    test_rewrite();
    test_sw_static();
    test_back_to_back();
    test_sop();
    test_negative();
    test_hazard();
    test_counter_clr();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
